// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - widths, FIFO entry type and rotate-right reference for rot_stream_ctrl
// The entry carries a parity bit only when ROT_PARITY_EN is defined.
package rot_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
`ifdef ROT_PARITY_EN
    logic              par;
`endif
  } rot_entry_t;

  localparam int ENTRY_W = $bits(rot_entry_t);

  function automatic logic [DATA_W-1:0] rot_ref(input logic [DATA_W-1:0] data,
                                                input logic [AMT_W-1:0]  amt);
    logic [2*DATA_W-1:0] w_wide;
    w_wide = {data, data} >> amt;
    return w_wide[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/rot_fifo.sv
// rtl/rot_fifo.sv - DEPTH-entry FIFO of packed rot_entry_t words, head shown combinationally
// DEPTH must be a power of 2 so the pointers wrap naturally.
module rot_fifo
  import rot_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_entry,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rot_stream_ctrl.sv
// rtl/rot_stream_ctrl.sv - byte stream through an external rotate-right unit into an output FIFO
// Optional ROT_PARITY_EN adds out_par, the even parity of each rotated byte.
module rot_stream_ctrl
  import rot_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              cfg_auto,
  output logic [DATA_W-1:0] shf_data,
  output logic [AMT_W-1:0]  shf_amt,
  input  logic [DATA_W-1:0] shf_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AMT_W-1:0]  out_amt,
`ifdef ROT_PARITY_EN
  output logic              out_par,
`endif
  output logic [CNT_W-1:0]  fifo_count
);

  localparam logic [CNT_W:0] L_DEPTH = (CNT_W + 1)'(DEPTH);

  logic              r_s1_v;
  logic [DATA_W-1:0] r_s1_data;
  logic [AMT_W-1:0]  r_s1_amt;
  logic [AMT_W-1:0]  r_amt_cnt;

  logic               w_accept;
  logic               w_pop;
  logic               w_empty;
  logic [CNT_W:0]     w_occupancy;
  logic [ENTRY_W-1:0] w_head_bits;
  rot_entry_t         w_push_entry;
  rot_entry_t         w_head;

  // Counting the S1 item as occupied reserves its FIFO slot, so a push never overflows
  // and in_ready depends only on registered state.
  assign w_occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, r_s1_v};
  assign in_ready    = rst_n && (w_occupancy < L_DEPTH);
  assign w_accept    = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_amt  <= '0;
      r_amt_cnt <= '0;
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_data <= in_data;
        r_s1_amt  <= cfg_auto ? r_amt_cnt : in_amt;
        if (cfg_auto) begin
          r_amt_cnt <= r_amt_cnt + AMT_W'(1);
        end
      end
    end
  end

  assign shf_data = r_s1_v ? r_s1_data : '0;
  assign shf_amt  = r_s1_v ? r_s1_amt  : '0;

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.data = shf_out;
    w_push_entry.amt  = r_s1_amt;
`ifdef ROT_PARITY_EN
    w_push_entry.par  = ^shf_out;
`else
`endif
  end

  rot_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_s1_v),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head_bits),
    .o_count (fifo_count),
    .o_empty (w_empty)
  );

  assign w_head    = rot_entry_t'(w_head_bits);
  assign out_valid = !w_empty;
  assign out_data  = w_head.data;
  assign out_amt   = w_head.amt;
`ifdef ROT_PARITY_EN
  assign out_par   = w_head.par;
`else
`endif

endmodule
